tlk2711_tx_sched: RTL and testbench

Transmit-side scheduler for the TLK2711 SerDes. It shares one TLK2711 TX lane among `NUM_CH` word-stream sources using round-robin arbitration. Each frame it carries is wrapped as SOF / channel header / payload / [CRC] / EOF, and the link is held in K28.5 idle between frames. It also owns link bring-up and the TLK2711 control pins. It sits between the per-channel packet FIFOs and the TLK2711 pin interface, in the `tx_clk` domain.

---
 rtl/tlk2711_tx_sched_if.sv | 13 +
 rtl/tlk2711_tx_sched.sv | 255 +++++++++++++++++++++++++
 tb/tb_tlk2711_tx_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlk2711_tx_sched_if.sv
// Per-channel word-stream handshake bundle between the packet FIFOs and the
// TLK2711 transmit scheduler; channel k owns s_data[16k+15:16k].
interface tlk2711_tx_sched_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]    s_valid;
  logic [NUM_CH*16-1:0] s_data;
  logic [NUM_CH-1:0]    s_last;
  logic [NUM_CH-1:0]    s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/tlk2711_tx_sched.sv
// Round-robin TX scheduler sharing one TLK2711 lane: SOF/HDR/payload/[CRC]/EOF framing,
// K28.5 idle fill, link bring-up and control pins. Optional CRC-16 via TLK2711_TX_CRC_EN.
module tlk2711_tx_sched #(
  parameter int NUM_CH    = 4,
  parameter int IDLE_GAP  = 2,
  parameter int INIT_IDLE = 64
) (
  input  logic                tx_clk,
  input  logic                rst,
  tlk2711_tx_sched_if.slave   src,
  input  logic                i_loopback_req,
  output logic [15:0]         o_txd,
  output logic                o_tkmsb,
  output logic                o_tklsb,
  output logic                o_enable,
  output logic                o_lckrefn,
  output logic                o_loopen,
  output logic                o_prbsen,
  output logic                o_testen,
  output logic                o_busy,
  output logic [2:0]          o_grant_ch
);

  localparam int GW = $clog2(IDLE_GAP + 1);
  localparam int IW = $clog2(INIT_IDLE + 1);

  localparam logic [15:0] W_IDLE = 16'hBCC5;
  localparam logic [15:0] W_SOF  = 16'hBCAB;
  localparam logic [15:0] W_EOF  = 16'hBCB5;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SOF,
    ST_HDR,
    ST_DATA,
`ifdef TLK2711_TX_CRC_EN
    ST_CRC,
`endif
    ST_EOF
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [IW-1:0]   init_cnt_q, init_cnt_d;
  logic [2:0]      last_q, last_d;

  logic [15:0]     txd_q, txd_d;
  logic            tkmsb_q, tkmsb_d;
  logic            tklsb_q, tklsb_d;
  logic            enable_q, enable_d;
  logic            lckrefn_q, lckrefn_d;
  logic            loopen_q, loopen_d;
  logic            busy_q, busy_d;
  logic [2:0]      grant_ch_q, grant_ch_d;

  logic            sel_valid;
  logic            sel_last;
  logic [15:0]     sel_data;
  logic            hs;
  logic            any_valid;
  logic            found;
  logic [2:0]      pick;

`ifdef TLK2711_TX_CRC_EN
  logic [15:0]     crc_q, crc_d;

  // CRC-16-CCITT over one 16-bit word, most significant bit (upper byte) first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int b = 15; b >= 0; b--) begin
      if (c[15] ^ data[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // Round-robin search from the channel after the last grant; also muxes the granted source.
  always_comb begin
    found     = 1'b0;
    pick      = last_q;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 16'h0000;
    any_valid = |src.s_valid;
    for (int i = 1; i <= NUM_CH; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!found && (k == (int'(last_q) + i) % NUM_CH) && src.s_valid[k]) begin
          found = 1'b1;
          pick  = 3'(k);
        end
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      src.s_ready[k] = (state_q == ST_DATA) && (last_q == 3'(k));
      if (last_q == 3'(k)) begin
        sel_valid = src.s_valid[k];
        sel_last  = src.s_last[k];
        sel_data  = src.s_data[16*k +: 16];
      end
    end
  end

  assign hs = (state_q == ST_DATA) && sel_valid;

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    init_cnt_d = init_cnt_q;
    last_d     = last_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q != IW'(INIT_IDLE)) init_cnt_d = init_cnt_q + IW'(1);
        if (init_cnt_q == IW'(INIT_IDLE - 1)) begin
          state_d = ST_IDLE;
          gap_d   = GW'(IDLE_GAP);
        end
      end
      ST_IDLE: begin
        if (gap_q != GW'(IDLE_GAP)) gap_d = gap_q + GW'(1);
        // A pending loopback request blocks new grants.
        if (!i_loopback_req && (gap_q == GW'(IDLE_GAP)) && any_valid && found) begin
          last_d  = pick;
          state_d = ST_SOF;
        end
      end
      ST_SOF: state_d = ST_HDR;
      ST_HDR: state_d = ST_DATA;
      ST_DATA: begin
        if (hs && sel_last) begin
`ifdef TLK2711_TX_CRC_EN
          state_d = ST_CRC;
`else
          state_d = ST_EOF;
`endif
        end
      end
`ifdef TLK2711_TX_CRC_EN
      ST_CRC: state_d = ST_EOF;
`endif
      ST_EOF: begin
        gap_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef TLK2711_TX_CRC_EN
  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_SOF) crc_d = 16'hFFFF;
    else if (hs)           crc_d = crc16_word(crc_q, sel_data);
  end
`endif

  // Pin decode of the current state; registered below, so pins trail the FSM by one cycle.
  always_comb begin
    txd_d      = W_IDLE;
    tkmsb_d    = 1'b1;
    tklsb_d    = 1'b0;
    enable_d   = 1'b1;
    lckrefn_d  = 1'b1;
    loopen_d   = 1'b0;
    busy_d     = 1'b0;
    grant_ch_d = grant_ch_q;
    unique case (state_q)
      ST_INIT: ;
      ST_IDLE: loopen_d = i_loopback_req;
      ST_SOF: begin
        txd_d      = W_SOF;
        busy_d     = 1'b1;
        grant_ch_d = last_q;
      end
      ST_HDR: begin
        txd_d      = {8'h00, 5'b00000, last_q};
        tkmsb_d    = 1'b0;
        busy_d     = 1'b1;
        grant_ch_d = last_q;
      end
      ST_DATA: begin
        busy_d     = 1'b1;
        grant_ch_d = last_q;
        if (hs) begin
          txd_d   = sel_data;
          tkmsb_d = 1'b0;
        end
      end
`ifdef TLK2711_TX_CRC_EN
      ST_CRC: begin
        txd_d      = crc_q;
        tkmsb_d    = 1'b0;
        busy_d     = 1'b1;
        grant_ch_d = last_q;
      end
`endif
      ST_EOF: begin
        txd_d      = W_EOF;
        busy_d     = 1'b1;
        grant_ch_d = last_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      gap_q      <= '0;
      init_cnt_q <= '0;
      last_q     <= 3'(NUM_CH - 1);
      txd_q      <= W_IDLE;
      tkmsb_q    <= 1'b1;
      tklsb_q    <= 1'b0;
      enable_q   <= 1'b0;
      lckrefn_q  <= 1'b0;
      loopen_q   <= 1'b0;
      busy_q     <= 1'b0;
      grant_ch_q <= 3'd0;
`ifdef TLK2711_TX_CRC_EN
      crc_q      <= 16'hFFFF;
`endif
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      init_cnt_q <= init_cnt_d;
      last_q     <= last_d;
      txd_q      <= txd_d;
      tkmsb_q    <= tkmsb_d;
      tklsb_q    <= tklsb_d;
      enable_q   <= enable_d;
      lckrefn_q  <= lckrefn_d;
      loopen_q   <= loopen_d;
      busy_q     <= busy_d;
      grant_ch_q <= grant_ch_d;
`ifdef TLK2711_TX_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign o_txd      = txd_q;
  assign o_tkmsb    = tkmsb_q;
  assign o_tklsb    = tklsb_q;
  assign o_enable   = enable_q;
  assign o_lckrefn  = lckrefn_q;
  assign o_loopen   = loopen_q;
  assign o_prbsen   = 1'b0;
  assign o_testen   = 1'b0;
  assign o_busy     = busy_q;
  assign o_grant_ch = grant_ch_q;

endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// Directed bench for tlk2711_tx_sched: bring-up, framing, round-robin, stall fills,
// loopback hold-off, one-word/CRC frame and mid-frame reset.
module tb_tlk2711_tx_sched;

  localparam int NUM_CH    = 4;
  localparam int IDLE_GAP  = 2;
  localparam int INIT_IDLE = 64;
`ifdef TLK2711_TX_CRC_EN
  localparam int CRC_EXTRA = 1;
`else
  localparam int CRC_EXTRA = 0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [3:0]  stall;
  } word_t;

  typedef struct packed {
    logic [15:0] txd;
    logic        tkmsb;
    logic        tklsb;
    logic        busy;
    logic        loopen;
    logic [2:0]  grant;
  } pins_t;

  logic        tx_clk = 1'b0;
  logic        rst;
  logic        i_loopback_req;
  logic [15:0] o_txd;
  logic        o_tkmsb, o_tklsb, o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen, o_busy;
  logic [2:0]  o_grant_ch;

  word_t       chq [NUM_CH][$];
  logic [3:0]  stall_left [NUM_CH];
  logic        pend [NUM_CH];
  pins_t       log_q [$];
  int          total;
  int          bad;

  int          rr_hdr_exp  [5] = '{0, 1, 2, 3, 0};
  int          rr_data_exp [5] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA010};
  int          sf_txd_exp  [7] = '{16'hBCC5, 16'hBCC5, 16'hBCAB, 16'h0002, 16'h1111, 16'h2222, 16'h3333};
  int          sf_tk_exp   [7] = '{1, 1, 1, 0, 0, 0, 0};

  always #5 tx_clk = ~tx_clk;

  tlk2711_tx_sched_if #(.NUM_CH(NUM_CH)) src_if ();

  tlk2711_tx_sched #(
    .NUM_CH   (NUM_CH),
    .IDLE_GAP (IDLE_GAP),
    .INIT_IDLE(INIT_IDLE)
  ) dut (
    .tx_clk        (tx_clk),
    .rst           (rst),
    .src           (src_if.slave),
    .i_loopback_req(i_loopback_req),
    .o_txd         (o_txd),
    .o_tkmsb       (o_tkmsb),
    .o_tklsb       (o_tklsb),
    .o_enable      (o_enable),
    .o_lckrefn     (o_lckrefn),
    .o_loopen      (o_loopen),
    .o_prbsen      (o_prbsen),
    .o_testen      (o_testen),
    .o_busy        (o_busy),
    .o_grant_ch    (o_grant_ch)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push_word(input int ch, input logic [15:0] data, input logic last, input logic [3:0] stall);
    word_t w;
    w.data  = data;
    w.last  = last;
    w.stall = stall;
    chq[ch].push_back(w);
  endtask

  // Present each channel's queue head, honouring any requested valid-low stall first.
  task automatic drive_sources();
    for (int k = 0; k < NUM_CH; k++) begin
      src_if.s_valid[k]        = 1'b0;
      src_if.s_last[k]         = 1'b0;
      src_if.s_data[16*k +: 16] = 16'h0000;
      if (chq[k].size() > 0) begin
        if (pend[k]) begin
          stall_left[k] = chq[k][0].stall;
          pend[k]       = 1'b0;
        end
        if (stall_left[k] != 4'd0) begin
          stall_left[k] = stall_left[k] - 4'd1;
        end else begin
          src_if.s_valid[k]         = 1'b1;
          src_if.s_last[k]          = chq[k][0].last;
          src_if.s_data[16*k +: 16] = chq[k][0].data;
        end
      end
    end
  endtask

  task automatic flush_sources();
    for (int k = 0; k < NUM_CH; k++) begin
      chq[k].delete();
      pend[k]       = 1'b1;
      stall_left[k] = 4'd0;
    end
    src_if.s_valid = '0;
    src_if.s_last  = '0;
    src_if.s_data  = '0;
  endtask

  // One clock: note handshakes, advance sources after the edge, log pins at the next negedge.
  task automatic step();
    logic [NUM_CH-1:0] hs;
    pins_t p;
    hs = src_if.s_valid & src_if.s_ready;
    @(posedge tx_clk);
    #1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (hs[k]) begin
        chq[k].delete(0);
        pend[k] = 1'b1;
      end
    end
    drive_sources();
    @(negedge tx_clk);
    p.txd    = o_txd;
    p.tkmsb  = o_tkmsb;
    p.tklsb  = o_tklsb;
    p.busy   = o_busy;
    p.loopen = o_loopen;
    p.grant  = o_grant_ch;
    log_q.push_back(p);
  endtask

  function automatic int find_txd(input int from, input logic [15:0] w);
    for (int i = from; i < log_q.size(); i++) begin
      if (log_q[i].txd == w) return i;
    end
    return -1;
  endfunction

  task automatic wait_sof(output logic found);
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (log_q[log_q.size()-1].txd == 16'hBCAB) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [NUM_CH-1:0] ready_or;
    logic found;
    int s, e, n, hdr_n, min_gap, gaps_n, j, cnt;

    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    i_loopback_req = 1'b0;
    flush_sources();

    // Reset values while rst is held
    repeat (2) @(negedge tx_clk);
    check_output("rst_txd",     32'(o_txd),          32'hBCC5);
    check_output("rst_tkmsb",   32'(o_tkmsb),        32'd1);
    check_output("rst_tklsb",   32'(o_tklsb),        32'd0);
    check_output("rst_enable",  32'(o_enable),       32'd0);
    check_output("rst_lckrefn", 32'(o_lckrefn),      32'd0);
    check_output("rst_loopen",  32'(o_loopen),       32'd0);
    check_output("rst_prbsen",  32'(o_prbsen),       32'd0);
    check_output("rst_testen",  32'(o_testen),       32'd0);
    check_output("rst_ready",   32'(src_if.s_ready), 32'd0);
    check_output("rst_busy",    32'(o_busy),         32'd0);
    check_output("rst_grant",   32'(o_grant_ch),     32'd0);

    // Bring-up
    rst = 1'b0;
    step();
    check_output("init_enable",  32'(o_enable),  32'd1);
    check_output("init_lckrefn", 32'(o_lckrefn), 32'd1);
    check_output("init_txd",     32'(o_txd),     32'hBCC5);
    ready_or = '0;
    repeat (INIT_IDLE) begin
      ready_or = ready_or | src_if.s_ready;
      step();
    end
    check_output("init_ready_low", 32'(ready_or), 32'd0);
    repeat (4) step();
    $display("[TB] bring-up done");

    // Round-robin: one-word frames on every channel plus a second on ch0
    log_q.delete();
    for (int k = 0; k < NUM_CH; k++) push_word(k, 16'(16'hA000 + k), 1'b1, 4'd0);
    push_word(0, 16'hA010, 1'b1, 4'd0);
    repeat (60) step();
    hdr_n   = 0;
    gaps_n  = 0;
    min_gap = 1000;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].txd == 16'hBCAB && hdr_n < 5) begin
        check_output($sformatf("rr_hdr%0d", hdr_n),  32'(log_q[i+1].txd), 32'(rr_hdr_exp[hdr_n]));
        check_output($sformatf("rr_data%0d", hdr_n), 32'(log_q[i+2].txd), 32'(rr_data_exp[hdr_n]));
        hdr_n++;
      end
      if (log_q[i].txd == 16'hBCB5) begin
        j = find_txd(i + 1, 16'hBCAB);
        if (j > 0) begin
          gaps_n++;
          if (j - i - 1 < min_gap) min_gap = j - i - 1;
        end
      end
    end
    check_output("rr_frames",  32'(hdr_n),  32'd5);
    check_output("rr_gaps",    32'(gaps_n), 32'd4);
    check_output("rr_min_gap", 32'(min_gap >= IDLE_GAP), 32'd1);

    // Single ch2 frame with exact grant latency
    log_q.delete();
    push_word(2, 16'h1111, 1'b0, 4'd0);
    push_word(2, 16'h2222, 1'b0, 4'd0);
    push_word(2, 16'h3333, 1'b1, 4'd0);
    repeat (12) step();
    for (int i = 0; i < 7; i++) begin
      check_output($sformatf("sf_txd%0d", i),   32'(log_q[i].txd),   32'(sf_txd_exp[i]));
      check_output($sformatf("sf_tkmsb%0d", i), 32'(log_q[i].tkmsb), 32'(sf_tk_exp[i]));
    end
    check_output("sf_eof",       32'(log_q[7+CRC_EXTRA].txd),   32'hBCB5);
    check_output("sf_eof_tkmsb", 32'(log_q[7+CRC_EXTRA].tkmsb), 32'd1);
    check_output("sf_idle0",     32'(log_q[8+CRC_EXTRA].txd),   32'hBCC5);
    check_output("sf_idle1",     32'(log_q[9+CRC_EXTRA].txd),   32'hBCC5);
    check_output("sf_grant",     32'(log_q[3].grant),           32'd2);
    check_output("sf_busy_sof",  32'(log_q[2].busy),            32'd1);
    check_output("sf_busy_pre",  32'(log_q[1].busy),            32'd0);
    check_output("sf_busy_post", 32'(log_q[8+CRC_EXTRA].busy),  32'd0);

    // Stall: ch1 drops valid for three cycles before its second word
    log_q.delete();
    push_word(1, 16'h4441, 1'b0, 4'd0);
    push_word(1, 16'h4442, 1'b0, 4'd3);
    push_word(1, 16'h4443, 1'b1, 4'd0);
    repeat (16) step();
    s = find_txd(0, 16'hBCAB);
    check_output("st_sof_found", 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    check_output("st_hdr",   32'(log_q[s+1].txd), 32'h0001);
    check_output("st_d0",    32'(log_q[s+2].txd), 32'h4441);
    for (int i = 3; i <= 5; i++) begin
      check_output($sformatf("st_fill%0d", i), 32'({log_q[s+i].txd, log_q[s+i].tkmsb}), 32'({16'hBCC5, 1'b1}));
    end
    check_output("st_fill_busy", 32'(log_q[s+4].busy),           32'd1);
    check_output("st_d1",        32'(log_q[s+6].txd),            32'h4442);
    check_output("st_d2",        32'(log_q[s+7].txd),            32'h4443);
    check_output("st_eof",       32'(log_q[s+8+CRC_EXTRA].txd),  32'hBCB5);

    // Loopback raised mid-frame on ch0, with another ch0 frame waiting
    log_q.delete();
    push_word(0, 16'h5551, 1'b0, 4'd0);
    push_word(0, 16'h5552, 1'b1, 4'd0);
    push_word(0, 16'h5553, 1'b1, 4'd0);
    wait_sof(found);
    check_output("lb_sof_found", 32'(found), 32'd1);
    s = log_q.size() - 1;
    step();
    i_loopback_req = 1'b1;
    repeat (20) step();
    e = find_txd(s, 16'hBCB5);
    check_output("lb_eof_found", 32'(e >= 0), 32'd1);
    if (e < 0) e = 0;
    check_output("lb_d0",          32'(log_q[s+2].txd),              32'h5551);
    check_output("lb_d1",          32'(log_q[s+3].txd),              32'h5552);
    check_output("lb_eof_pos",     32'(e),                           32'(s + 4 + CRC_EXTRA));
    check_output("lb_loopen_eof",  32'(log_q[e].loopen),             32'd0);
    check_output("lb_loopen_idle", 32'(log_q[e+1].loopen),           32'd1);
    check_output("lb_loopen_hold", 32'(log_q[log_q.size()-1].loopen), 32'd1);
    check_output("lb_no_sof",      32'(find_txd(s + 1, 16'hBCAB) < 0), 32'd1);
    check_output("lb_busy_hold",   32'(log_q[log_q.size()-1].busy),   32'd0);
    n = log_q.size();
    i_loopback_req = 1'b0;
    repeat (10) step();
    j = find_txd(n, 16'hBCAB);
    check_output("lb_resume_sof", 32'(j >= 0), 32'd1);
    if (j < 0) j = 0;
    check_output("lb_resume_loopen", 32'(log_q[j].loopen),  32'd0);
    check_output("lb_resume_data",   32'(log_q[j+2].txd),   32'h5553);

    // One-word payload of 0x0000 on ch0 (CRC word 0x1D0F when enabled)
    repeat (4) step();
    log_q.delete();
    push_word(0, 16'h0000, 1'b1, 4'd0);
    repeat (12) step();
    s = find_txd(0, 16'hBCAB);
    check_output("ow_sof_found", 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    check_output("ow_hdr",   32'({log_q[s+1].txd, log_q[s+1].tkmsb}), 32'({16'h0000, 1'b0}));
    check_output("ow_data",  32'({log_q[s+2].txd, log_q[s+2].tkmsb}), 32'({16'h0000, 1'b0}));
`ifdef TLK2711_TX_CRC_EN
    check_output("ow_crc",   32'({log_q[s+3].txd, log_q[s+3].tkmsb}), 32'({16'h1D0F, 1'b0}));
`endif
    check_output("ow_eof",   32'(log_q[s+3+CRC_EXTRA].txd), 32'hBCB5);

    // Reset in the middle of a ch3 frame aborts without EOF
    repeat (4) step();
    push_word(3, 16'h7771, 1'b0, 4'd0);
    push_word(3, 16'h7772, 1'b0, 4'd0);
    push_word(3, 16'h7773, 1'b0, 4'd0);
    push_word(3, 16'h7774, 1'b1, 4'd0);
    wait_sof(found);
    check_output("mr_sof_found", 32'(found), 32'd1);
    repeat (2) step();
    check_output("mr_busy_before", 32'(o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_output("mr_txd",     32'(o_txd),          32'hBCC5);
    check_output("mr_tkmsb",   32'(o_tkmsb),        32'd1);
    check_output("mr_enable",  32'(o_enable),       32'd0);
    check_output("mr_busy",    32'(o_busy),         32'd0);
    check_output("mr_ready",   32'(src_if.s_ready), 32'd0);
    check_output("mr_grant",   32'(o_grant_ch),     32'd0);
    flush_sources();
    repeat (2) @(negedge tx_clk);
    rst = 1'b0;
    log_q.delete();
    repeat (10) step();
    cnt = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].txd != 16'hBCC5) cnt++;
    end
    check_output("mr_all_idle",  32'(cnt),      32'd0);
    check_output("mr_re_enable", 32'(o_enable), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
